mc_latency_resp: RTL and testbench

MC_LATENCY_RESP -- requirements
Module: mc_latency_resp

---
 rtl/mc_latency_resp_if.sv | 40 ++++
 rtl/mc_latency_resp.sv | 146 ++++++++++++++
 tb/tb_mc_latency_resp.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_latency_resp_if.sv
// mc_latency_resp_if: request/response bus between a requester and the
// fixed-latency memory responder.
//   mc_rq_*  : request from requester (vld, cmd, scmd, vadr, size, rtnctl,
//              data, flush); mc_rq_stall is advisory backpressure back to it.
//   mc_rs_*  : response to requester (vld, cmd, scmd, rtnctl, data);
//              mc_rs_stall is the requester's "cannot accept" signal.
// Modports: master = requester side, slave = responder side.
interface mc_latency_resp_if #(
   parameter int MC_RTNCTL_WIDTH = 32
);
   logic                       mc_rq_vld;
   logic [2:0]                 mc_rq_cmd;
   logic [3:0]                 mc_rq_scmd;
   logic [47:0]                mc_rq_vadr;
   logic [1:0]                 mc_rq_size;
   logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
   logic [63:0]                mc_rq_data;
   logic                       mc_rq_flush;
   logic                       mc_rq_stall;
   logic                       mc_rs_vld;
   logic [2:0]                 mc_rs_cmd;
   logic [3:0]                 mc_rs_scmd;
   logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
   logic [63:0]                mc_rs_data;
   logic                       mc_rs_stall;

   modport master (
      output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
             mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
      input  mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
             mc_rs_data
   );

   modport slave (
      input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
             mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
      output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
             mc_rs_data
   );
endinterface

// File: rtl/mc_latency_resp.sv
// mc_latency_resp: fixed-latency memory responder model.
// Every valid request is accepted; legal reads/writes (and flushes) travel
// a LATENCY-deep delay line into an in-order response FIFO and are returned
// through a registered response port that honours mc_rs_stall one cycle
// ahead. Outstanding work is capped at FIFO_DEPTH; excess requests are
// dropped and flagged.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   bus (slave)   : mc_rq_* request in, mc_rq_stall out, mc_rs_* response out
//   err_overflow  : sticky, request dropped at full capacity
//   err_badcmd    : sticky, illegal command received
module mc_latency_resp #(
   parameter int MC_RTNCTL_WIDTH = 32,
   parameter int RAM_DEPTH       = 1024,
   parameter int LATENCY         = 4,
   parameter int FIFO_DEPTH      = 16,
   parameter int STALL_SLACK     = 2
) (
   input  logic             clk,
   input  logic             reset,
   mc_latency_resp_if.slave bus,
   output logic             err_overflow,
   output logic             err_badcmd
);
   localparam int AW     = $clog2(RAM_DEPTH);
   localparam int FW     = $clog2(FIFO_DEPTH);
   localparam int CW     = $clog2(FIFO_DEPTH + 1);
   localparam int STAGES = LATENCY - 1;

   typedef struct packed {
      logic [2:0]                 cmd;
      logic [3:0]                 scmd;
      logic [MC_RTNCTL_WIDTH-1:0] rtnctl;
      logic [63:0]                data;
   } ent_t;

   logic [63:0]   mem [RAM_DEPTH];
   ent_t          fifo [FIFO_DEPTH];
   logic [FW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] fifo_cnt, count_q;
   logic          out_vld;
   ent_t          out_ent;

   logic [AW-1:0] widx;
   logic          is_rd, is_wr, is_bad, is_flush, want, full, new_vld;
   ent_t          new_ent, tail;
   logic          tail_vld;
   logic          take, from_fifo, push, pop;
   logic          unused_ok;

   assign widx      = bus.mc_rq_vadr[3 +: AW];
   assign unused_ok = ^{bus.mc_rq_size, bus.mc_rq_vadr[2:0], bus.mc_rq_vadr[47:3+AW]};

   always_comb begin
      is_rd    = bus.mc_rq_vld && (bus.mc_rq_cmd == 3'd1);
      is_wr    = bus.mc_rq_vld && (bus.mc_rq_cmd == 3'd2);
      is_bad   = bus.mc_rq_vld && !is_rd && !is_wr;
      is_flush = !bus.mc_rq_vld && bus.mc_rq_flush;
      want     = is_rd || is_wr || is_flush;
      full     = (count_q == CW'(FIFO_DEPTH));
      new_vld  = want && !full;
      // Read data is sampled combinationally, so a write on this same edge
      // is not visible to it.
      new_ent.cmd    = is_rd ? 3'd2 : 3'd3;
      new_ent.scmd   = is_flush ? 4'hF : bus.mc_rq_scmd;
      new_ent.rtnctl = is_flush ? '0 : bus.mc_rq_rtnctl;
      new_ent.data   = is_rd ? mem[widx] : 64'd0;
   end

   // Memory survives reset on purpose.
   always_ff @(posedge clk) begin
      if (!reset && is_wr && !full) mem[widx] <= bus.mc_rq_data;
   end

   // The output register is the last latency stage, so the delay line
   // itself holds LATENCY-1 stages.
   generate
      if (STAGES == 0) begin : g_bypass
         assign tail     = new_ent;
         assign tail_vld = new_vld;
      end else begin : g_pipe
         logic [STAGES-1:0] vld_pipe;
         ent_t              pipe_q [STAGES];

         always_ff @(posedge clk) begin
            if (reset) begin
               vld_pipe <= '0;
            end else begin
               vld_pipe[0] <= new_vld;
               for (int i = 1; i < STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
            end
         end

         always_ff @(posedge clk) begin
            pipe_q[0] <= new_ent;
            for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
         end

         assign tail     = pipe_q[STAGES-1];
         assign tail_vld = vld_pipe[STAGES-1];
      end
   endgenerate

   // Output loads only when the requester was not stalling; FIFO head has
   // priority, otherwise the tail entry bypasses the empty FIFO.
   always_comb begin
      from_fifo = (fifo_cnt != '0);
      take      = !bus.mc_rs_stall && (from_fifo || tail_vld);
      pop       = take && from_fifo;
      push      = tail_vld && !(take && !from_fifo);
   end

   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= tail;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_cnt     <= '0;
         count_q      <= '0;
         out_vld      <= 1'b0;
         out_ent      <= '0;
         err_overflow <= 1'b0;
         err_badcmd   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FW'(1);
         if (pop)  rd_ptr <= rd_ptr + FW'(1);
         fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
         out_vld  <= take;
         out_ent  <= take ? (from_fifo ? fifo[rd_ptr] : tail) : '0;
         // A response is delivered in the cycle its valid is high.
         count_q  <= count_q + CW'(new_vld) - CW'(out_vld);
         if (want && full) err_overflow <= 1'b1;
         if (is_bad)       err_badcmd   <= 1'b1;
      end
   end

   assign bus.mc_rs_vld    = out_vld;
   assign bus.mc_rs_cmd    = out_ent.cmd;
   assign bus.mc_rs_scmd   = out_ent.scmd;
   assign bus.mc_rs_rtnctl = out_ent.rtnctl;
   assign bus.mc_rs_data   = out_ent.data;
   assign bus.mc_rq_stall  = (count_q >= CW'(FIFO_DEPTH - STALL_SLACK));
endmodule

// File: tb/tb_mc_latency_resp.sv
// Bench for mc_latency_resp: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_mc_latency_resp;
   localparam int LAT = 4, FD = 16, SLACK = 2;

   logic clk = 1'b0;
   logic reset;
   logic err_overflow, err_badcmd;

   mc_latency_resp_if #(.MC_RTNCTL_WIDTH(32)) bus();

   mc_latency_resp dut (
      .clk(clk), .reset(reset), .bus(bus),
      .err_overflow(err_overflow), .err_badcmd(err_badcmd)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  cmd;
      logic [3:0]  scmd;
      logic [31:0] tag;
      logic [63:0] data;
      int          ready;
   } exp_t;

   typedef struct {
      bit          v;
      logic [2:0]  cmd;
      logic [47:0] vadr;
      logic [31:0] tag;
      logic [63:0] data;
      bit          e_vld;
      logic [2:0]  e_cmd;
      logic [31:0] e_tag;
      logic [63:0] e_data;
   } vec_t;

   exp_t        pend[$];
   logic [63:0] mem_m [int];
   int          wlist[$];
   logic [2:0]  log_cmd[$];
   logic [3:0]  log_scmd[$];
   int          cnt_m = 0, cyc_n = 0, nresp = 0;
   bit          prev_stall = 0, ovf_m = 0, bad_m = 0, model_ok = 0;
   int          n_chk = 0, n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   function automatic logic [47:0] mkva(input int idx);
      logic [47:0] va;
      va = 48'({$urandom(), $urandom()});
      va[12:3] = 10'(idx);
      return va;
   endfunction

   // One clock cycle: drive inputs, compare this cycle's outputs with the
   // model, then advance the model across the edge.
   task automatic cyc(input bit v, input logic [2:0] cmd, input logic [3:0] scmd,
                      input logic [47:0] vadr, input logic [31:0] tag,
                      input logic [63:0] data, input bit fl, input bit st, input bit rst);
      int   cnt0, idx;
      bit   e_vld;
      exp_t e;
      reset = rst;
      bus.mc_rq_vld = v; bus.mc_rq_cmd = cmd; bus.mc_rq_scmd = scmd;
      bus.mc_rq_vadr = vadr; bus.mc_rq_size = 2'(cyc_n); bus.mc_rq_rtnctl = tag;
      bus.mc_rq_data = data; bus.mc_rq_flush = fl; bus.mc_rs_stall = st;
      cnt0 = cnt_m;
      if (model_ok) begin
         e_vld = !prev_stall && pend.size() > 0 && pend[0].ready <= cyc_n;
         chk("rs_vld", 64'(bus.mc_rs_vld), 64'(e_vld));
         if (e_vld) begin
            e = pend.pop_front();
            cnt_m--;
            chk("rs_cmd", 64'(bus.mc_rs_cmd), 64'(e.cmd));
            chk("rs_scmd", 64'(bus.mc_rs_scmd), 64'(e.scmd));
            chk("rs_rtnctl", 64'(bus.mc_rs_rtnctl), 64'(e.tag));
            chk("rs_data", bus.mc_rs_data, e.data);
         end
         if (bus.mc_rs_vld === 1'b1) begin
            nresp++;
            log_cmd.push_back(bus.mc_rs_cmd);
            log_scmd.push_back(bus.mc_rs_scmd);
         end
         chk("rq_stall", 64'(bus.mc_rq_stall), 64'(cnt0 >= FD - SLACK));
         chk("err_overflow", 64'(err_overflow), 64'(ovf_m));
         chk("err_badcmd", 64'(err_badcmd), 64'(bad_m));
      end
      if (rst) begin
         pend.delete(); cnt_m = 0; ovf_m = 0; bad_m = 0; model_ok = 1;
      end else begin
         idx = int'(vadr[12:3]);
         if (v && !(cmd inside {3'd1, 3'd2})) bad_m = 1;
         else if (v || fl) begin
            if (cnt0 == FD) ovf_m = 1;
            else begin
               e.ready = cyc_n + LAT;
               if (!v) begin
                  e.cmd = 3'd3; e.scmd = 4'hF; e.tag = '0; e.data = '0;
               end else if (cmd == 3'd1) begin
                  e.cmd = 3'd2; e.scmd = scmd; e.tag = tag; e.data = mem_m[idx];
               end else begin
                  e.cmd = 3'd3; e.scmd = scmd; e.tag = tag; e.data = '0;
                  if (!mem_m.exists(idx)) wlist.push_back(idx);
                  mem_m[idx] = data;
               end
               pend.push_back(e);
               cnt_m++;
            end
         end
      end
      prev_stall = st;
      cyc_n++;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n, input bit st);
      for (int i = 0; i < n; i++) cyc(0, 3'd0, 4'h0, 48'h0, 32'h0, 64'h0, 0, st, 0);
   endtask

   task automatic rd(input int idx, input logic [31:0] tag, input bit st);
      cyc(1, 3'd1, 4'h3, mkva(idx), tag, 64'h0, 0, st, 0);
   endtask

   task automatic wr(input int idx, input logic [31:0] tag, input logic [63:0] d, input bit st);
      cyc(1, 3'd2, 4'h4, mkva(idx), tag, d, 0, st, 0);
   endtask

   vec_t tbl [9];
   int   mark, r;
   bit   st;

   initial begin
      tbl[0] = '{1, 3'd2, 48'h40,   32'd5, 64'hDEADBEEF,          0, 3'd0, 32'd0, 64'h0};
      tbl[1] = '{1, 3'd1, 48'h40,   32'd6, 64'h0,                 0, 3'd0, 32'd0, 64'h0};
      tbl[2] = '{1, 3'd2, 48'h2040, 32'd7, 64'h123456789ABCDEF0,  0, 3'd0, 32'd0, 64'h0};
      tbl[3] = '{1, 3'd1, 48'h40,   32'd8, 64'h0,                 0, 3'd0, 32'd0, 64'h0};
      tbl[4] = '{0, 3'd0, 48'h0,    32'd0, 64'h0,                 1, 3'd3, 32'd5, 64'h0};
      tbl[5] = '{0, 3'd0, 48'h0,    32'd0, 64'h0,                 1, 3'd2, 32'd6, 64'hDEADBEEF};
      tbl[6] = '{0, 3'd0, 48'h0,    32'd0, 64'h0,                 1, 3'd3, 32'd7, 64'h0};
      tbl[7] = '{0, 3'd0, 48'h0,    32'd0, 64'h0,                 1, 3'd2, 32'd8, 64'h123456789ABCDEF0};
      tbl[8] = '{0, 3'd0, 48'h0,    32'd0, 64'h0,                 0, 3'd0, 32'd0, 64'h0};

      // reset
      cyc(0, 3'd0, 4'h0, 48'h0, 32'h0, 64'h0, 0, 0, 1);
      cyc(0, 3'd0, 4'h0, 48'h0, 32'h0, 64'h0, 0, 0, 1);
      chk("reset_rs_vld", 64'(bus.mc_rs_vld), 64'd0);
      chk("reset_rq_stall", 64'(bus.mc_rq_stall), 64'd0);
      chk("reset_rs_data", bus.mc_rs_data, 64'd0);
      chk("reset_err_ovf", 64'(err_overflow), 64'd0);

      // directed table: write/read latency and address wrap
      for (int i = 0; i < 9; i++) begin
         chk("tbl_vld", 64'(bus.mc_rs_vld), 64'(tbl[i].e_vld));
         if (tbl[i].e_vld) begin
            chk("tbl_cmd", 64'(bus.mc_rs_cmd), 64'(tbl[i].e_cmd));
            chk("tbl_tag", 64'(bus.mc_rs_rtnctl), 64'(tbl[i].e_tag));
            chk("tbl_data", bus.mc_rs_data, tbl[i].e_data);
         end
         cyc(tbl[i].v, tbl[i].cmd, 4'h1, tbl[i].vadr, tbl[i].tag, tbl[i].data, 0, 0, 0);
      end

      // illegal command, then flush after two writes
      mark = nresp;
      cyc(1, 3'd5, 4'h2, 48'h80, 32'd99, 64'h55, 0, 0, 0);
      chk("badcmd_flag", 64'(err_badcmd), 64'd1);
      wr(1, 32'd11, 64'hA1, 0);
      wr(2, 32'd12, 64'hA2, 0);
      cyc(0, 3'd0, 4'h0, 48'h0, 32'h0, 64'h0, 1, 0, 0);
      idle(10, 0);
      chk("flush_count", 64'(nresp - mark), 64'd3);
      if (log_cmd.size() >= mark + 3) begin
         chk("flush_cmd", 64'(log_cmd[mark+2]), 64'd3);
         chk("flush_scmd", 64'(log_scmd[mark+2]), 64'hF);
      end

      // 8 queued reads drained while stall toggles every cycle
      mark = nresp;
      for (int i = 0; i < 8; i++) rd(wlist[i % wlist.size()], 32'(100 + i), 1);
      for (int i = 0; i < 30; i++) idle(1, i[0]);
      idle(5, 0);
      chk("toggle_count", 64'(nresp - mark), 64'd8);

      // fill to capacity with responses held off
      idle(10, 0);
      mark = nresp;
      for (int i = 0; i < 17; i++) begin
         rd(wlist[i % wlist.size()], 32'(200 + i), 1);
         if (i == 12) chk("stall_at13", 64'(bus.mc_rq_stall), 64'd0);
         if (i == 13) chk("stall_at14", 64'(bus.mc_rq_stall), 64'd1);
      end
      chk("overflow_flag", 64'(err_overflow), 64'd1);
      idle(25, 0);
      chk("overflow_count", 64'(nresp - mark), 64'd16);

      // reset with 5 responses pending
      for (int i = 0; i < 5; i++) rd(wlist[0], 32'(300 + i), 1);
      idle(LAT + 1, 1);
      cyc(0, 3'd0, 4'h0, 48'h0, 32'h0, 64'h0, 0, 1, 1);
      chk("rst_rs_vld", 64'(bus.mc_rs_vld), 64'd0);
      chk("rst_rs_cmd", 64'(bus.mc_rs_cmd), 64'd0);
      chk("rst_rs_scmd", 64'(bus.mc_rs_scmd), 64'd0);
      chk("rst_rs_tag", 64'(bus.mc_rs_rtnctl), 64'd0);
      chk("rst_rs_data", bus.mc_rs_data, 64'd0);
      chk("rst_rq_stall", 64'(bus.mc_rq_stall), 64'd0);
      chk("rst_err_ovf", 64'(err_overflow), 64'd0);
      chk("rst_err_bad", 64'(err_badcmd), 64'd0);
      mark = nresp;
      idle(12, 0);
      chk("rst_no_resp", 64'(nresp - mark), 64'd0);

      // randomized traffic with alternating light/heavy response stall
      for (int i = 0; i < 8; i++) wr(i, 32'(400 + i), {$urandom(), $urandom()}, 0);
      for (int i = 0; i < 1500; i++) begin
         r  = $urandom_range(0, 99);
         st = ($urandom_range(0, 99) < (((i / 100) % 2) != 0 ? 85 : 20));
         if (r < 35)
            cyc(1, 3'd1, 4'($urandom), mkva(wlist[$urandom_range(0, wlist.size() - 1)]),
                $urandom(), 64'h0, ($urandom_range(0, 9) == 0), st, 0);
         else if (r < 60)
            cyc(1, 3'd2, 4'($urandom), mkva($urandom_range(0, 31)), $urandom(),
                {$urandom(), $urandom()}, ($urandom_range(0, 9) == 0), st, 0);
         else if (r < 66)
            cyc(0, 3'($urandom), 4'($urandom), 48'h0, $urandom(), 64'h0, 1, st, 0);
         else if (r < 68)
            cyc(1, 3'($urandom_range(3, 7)), 4'h0, 48'h0, 32'h0, 64'h0, 0, st, 0);
         else
            idle(1, st);
      end
      idle(30, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
